// File: rtl/dma_cfg_pkg.sv
// Shared types and constants for the DMA configuration responder.
package dma_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    LEN     = 2'd1,
    ALIGN   = 2'd2,
    TIMEOUT = 2'd3
  } err_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [31:0] src, input logic [31:0] dst,
                                      input logic [31:0] len);
    return |((src[1:0] | dst[1:0] | len[1:0]) & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/dma_cfg_slave_if.sv
// Configuration command bus plus descriptor handshake towards the DMA engine.
interface dma_cfg_slave_if;

  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;
  logic        start;
  logic        done;
  logic [1:0]  err_code;
  logic        busy;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_src;
  logic [31:0] desc_dst;
  logic [31:0] desc_len;
  logic        eng_done;
  logic        eng_abort;

  modport slave (
    input  src_addr, dst_addr, length, start, desc_ready, eng_done,
    output done, err_code, busy, desc_valid, desc_src, desc_dst, desc_len, eng_abort
  );

  modport master (
    output src_addr, dst_addr, length, start, desc_ready, eng_done,
    input  done, err_code, busy, desc_valid, desc_src, desc_dst, desc_len, eng_abort
  );

endinterface

// File: rtl/dma_cfg_watchdog.sv
// Engine watchdog: counts enabled cycles since clear, flags the last allowed cycle.
module dma_cfg_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (enable && !expired) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/dma_cfg_slave.sv
// DMA configuration responder: latch, validate, issue descriptor, await engine, report done.
// Optional alignment check enabled by defining CFG_ALIGN_CHECK_EN.
module dma_cfg_slave
  import dma_cfg_pkg::*;
#(
  parameter logic [31:0] MAX_LEN        = 32'h0010_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            reset,
  dma_cfg_slave_if.slave bus
);

  state_e      state;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] len_q;
  logic        desc_valid_q;
  logic        done_q;
  err_e        err_q;
  logic        abort_q;
  logic        busy_q;
  logic        align_fault;
  logic        wd_clear;
  logic        wd_expired;

`ifdef CFG_ALIGN_CHECK_EN
  assign align_fault = misaligned(src_q, dst_q, len_q);
`else
  assign align_fault = 1'b0;
`endif

  // Counter restarts on the handshake edge so the first BUSY cycle sees count 0.
  assign wd_clear = (state == ISSUE) && bus.desc_ready;

  dma_cfg_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (state == BUSY),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      desc_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= OK;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= OK;
      abort_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            len_q  <= bus.length;
            busy_q <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if ((len_q == '0) || (len_q > MAX_LEN)) begin
            done_q <= 1'b1;
            err_q  <= LEN;
            state  <= DONE;
          end else if (align_fault) begin
            done_q <= 1'b1;
            err_q  <= ALIGN;
            state  <= DONE;
          end else begin
            desc_valid_q <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.desc_ready) begin
            desc_valid_q <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Engine completion beats a coincident watchdog expiry.
          if (bus.eng_done) begin
            done_q <= 1'b1;
            err_q  <= OK;
            state  <= DONE;
          end else if (wd_expired) begin
            done_q  <= 1'b1;
            err_q   <= TIMEOUT;
            abort_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          desc_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.err_code   = err_q;
  assign bus.eng_abort  = abort_q;
  assign bus.busy       = busy_q;
  assign bus.desc_valid = desc_valid_q;
  assign bus.desc_src   = src_q;
  assign bus.desc_dst   = dst_q;
  assign bus.desc_len   = len_q;

endmodule

// File: tb/tb_dma_cfg_slave.sv
// Randomized self-checking bench for dma_cfg_slave against a latency/status reference model.
module tb_dma_cfg_slave;

  localparam logic [31:0] MAX_LEN = 32'h0010_0000;
  localparam int          TO      = 8;
`ifdef CFG_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef struct {
    int         done_at;
    logic [1:0] err;
    logic       abort;
    int         vcyc;
    int         bad_fields;
    int         ndone;
    int         nabort;
    int         busy_bad;
    int         stray_err;
  } res_t;

  typedef struct {
    int         done_at;
    logic [1:0] err;
    logic       abort;
    int         vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dma_cfg_slave_if bus ();

  dma_cfg_slave #(
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Cycle numbers count from the cycle in which start is driven (cycle 0).
  function automatic exp_t predict(input logic [31:0] s, input logic [31:0] d,
                                   input logic [31:0] l, input int rw, input int el);
    exp_t e;
    int   b;
    e.done_at = 2;
    e.err     = 2'd0;
    e.abort   = 1'b0;
    e.vcyc    = 0;
    if (l == 0 || l > MAX_LEN) begin
      e.err = 2'd1;
      return e;
    end
    if (ALIGN_EN && ((s % 4) != 0 || (d % 4) != 0 || (l % 4) != 0)) begin
      e.err = 2'd2;
      return e;
    end
    e.vcyc = rw + 1;
    b      = 3 + rw;
    if (el >= 0 && el < TO) begin
      e.done_at = b + el + 1;
    end else begin
      e.done_at = b + TO;
      e.err     = 2'd3;
      e.abort   = 1'b1;
    end
    return e;
  endfunction

  task automatic do_cmd(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input int rw, input int el, input bit poke, input bit noise,
                        output res_t r);
    int c;
    int b;
    bit seen;
    int after;
    bit exp_busy;
    r.done_at = -1; r.err = 2'b0; r.abort = 1'b0; r.vcyc = 0; r.bad_fields = 0;
    r.ndone = 0; r.nabort = 0; r.busy_bad = 0; r.stray_err = 0;
    b = -1; seen = 1'b0; after = 0; c = 0;
    bus.src_addr = s; bus.dst_addr = d; bus.length = l;
    bus.start = 1'b1; bus.desc_ready = 1'b0; bus.eng_done = 1'b0;
    while (c < 80 && after < 3) begin
      @(posedge clk); #1;
      c++;
      if (bus.done === 1'b1) begin
        r.ndone++;
        if (!seen) begin
          seen = 1'b1; r.done_at = c; r.err = bus.err_code; r.abort = bus.eng_abort;
        end
      end else if (bus.err_code !== 2'b0) begin
        r.stray_err++;
      end
      if (bus.eng_abort === 1'b1) r.nabort++;
      exp_busy = !(seen && c > r.done_at);
      if (bus.busy !== exp_busy) r.busy_bad++;
      if (seen) after++;
      bus.start      = (poke && (!seen || c == r.done_at)) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.src_addr   = $urandom;
      bus.dst_addr   = $urandom;
      bus.length     = $urandom;
      bus.desc_ready = 1'b0;
      bus.eng_done   = 1'b0;
      if (bus.desc_valid === 1'b1) begin
        r.vcyc++;
        if ({bus.desc_src, bus.desc_dst, bus.desc_len} !== {s, d, l}) r.bad_fields++;
        if (r.vcyc > rw) begin
          bus.desc_ready = 1'b1;
          b = c + 1;
        end else if (noise) begin
          bus.eng_done = 1'($urandom_range(0, 1));
        end
      end
      if (b >= 0 && el >= 0 && c == b + el) bus.eng_done = 1'b1;
    end
    bus.start = 1'b0; bus.desc_ready = 1'b0; bus.eng_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.desc_ready = 1'b0; bus.eng_done = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.err_code, bus.busy, bus.desc_valid, bus.eng_abort} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.done, bus.err_code, bus.busy, bus.desc_valid, bus.eng_abort});
    end
    checks++;
    if ({bus.desc_src, bus.desc_dst, bus.desc_len} !== 96'b0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0", {bus.desc_src, bus.desc_dst, bus.desc_len});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    res_t r;
    do_cmd(32'h1000, 32'h2000, 32'h40, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.done_at !== 4) begin errors++; $display("FAIL basic_done_at: got %0d expected 4", r.done_at); end
    checks++;
    if (r.err !== 2'd0) begin errors++; $display("FAIL basic_err: got %0d expected 0", r.err); end
    checks++;
    if (r.vcyc !== 1 || r.bad_fields !== 0) begin
      errors++; $display("FAIL basic_desc: got vcyc=%0d bad=%0d expected vcyc=1 bad=0", r.vcyc, r.bad_fields);
    end
    checks++;
    if (r.ndone !== 1 || r.busy_bad !== 0 || r.nabort !== 0) begin
      errors++; $display("FAIL basic_pulses: got ndone=%0d busy_bad=%0d nabort=%0d expected 1 0 0",
                         r.ndone, r.busy_bad, r.nabort);
    end
  endtask

  task automatic test_len_reject();
    logic [31:0] lens[2];
    res_t r;
    lens[0] = 32'h0;
    lens[1] = MAX_LEN + 32'd1;
    foreach (lens[i]) begin
      do_cmd(32'h1000, 32'h2000, lens[i], 0, 0, 1'b0, 1'b0, r);
      checks++;
      if (r.done_at !== 2 || r.err !== 2'd1) begin
        errors++; $display("FAIL len_reject[%0d]: got done_at=%0d err=%0d expected 2 1", i, r.done_at, r.err);
      end
      checks++;
      if (r.vcyc !== 0 || r.ndone !== 1) begin
        errors++; $display("FAIL len_reject_desc[%0d]: got vcyc=%0d ndone=%0d expected 0 1", i, r.vcyc, r.ndone);
      end
    end
  endtask

  task automatic test_align();
    res_t r;
    exp_t e;
    e = predict(32'h1002, 32'h2000, 32'h40, 0, 0);
    do_cmd(32'h1002, 32'h2000, 32'h40, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.done_at !== e.done_at || r.err !== e.err || r.vcyc !== e.vcyc) begin
      errors++; $display("FAIL align: got done_at=%0d err=%0d vcyc=%0d expected %0d %0d %0d",
                         r.done_at, r.err, r.vcyc, e.done_at, e.err, e.vcyc);
    end
  endtask

  task automatic test_timeout();
    res_t r;
    do_cmd(32'h100, 32'h200, 32'h10, 0, -1, 1'b0, 1'b0, r);
    checks++;
    if (r.done_at !== 3 + TO || r.err !== 2'd3) begin
      errors++; $display("FAIL timeout: got done_at=%0d err=%0d expected %0d 3", r.done_at, r.err, 3 + TO);
    end
    checks++;
    if (r.abort !== 1'b1 || r.nabort !== 1) begin
      errors++; $display("FAIL timeout_abort: got abort=%0d nabort=%0d expected 1 1", r.abort, r.nabort);
    end
    do_cmd(32'h100, 32'h200, 32'h10, 0, TO - 1, 1'b0, 1'b0, r);
    checks++;
    if (r.done_at !== 3 + TO || r.err !== 2'd0 || r.nabort !== 0) begin
      errors++; $display("FAIL timeout_tie: got done_at=%0d err=%0d nabort=%0d expected %0d 0 0",
                         r.done_at, r.err, r.nabort, 3 + TO);
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    do_cmd(32'hA000, 32'hB000, 32'h100, 5, 2, 1'b1, 1'b1, r);
    checks++;
    if (r.vcyc !== 6 || r.bad_fields !== 0) begin
      errors++; $display("FAIL bp_desc: got vcyc=%0d bad=%0d expected 6 0", r.vcyc, r.bad_fields);
    end
    checks++;
    if (r.done_at !== 11 || r.err !== 2'd0 || r.ndone !== 1) begin
      errors++; $display("FAIL bp_done: got done_at=%0d err=%0d ndone=%0d expected 11 0 1",
                         r.done_at, r.err, r.ndone);
    end
  endtask

  task automatic test_random();
    res_t        r;
    exp_t        e;
    logic [31:0] s, d, l;
    int          rw, el;
    bit          poke, noise;
    for (int n = 0; n < 40; n++) begin
      s = $urandom; d = $urandom;
      if ($urandom_range(0, 1) == 1) s[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) d[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0:       l = 32'h0;
        1:       l = MAX_LEN;
        2:       l = MAX_LEN + 32'd1;
        3:       l = $urandom | 32'h8000_0000;
        4:       l = 32'($urandom_range(1, 4096)) << 2;
        default: l = 32'($urandom_range(1, 4096));
      endcase
      rw    = int'($urandom_range(0, 4));
      el    = int'($urandom_range(0, 10)) - 1;
      poke  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      e = predict(s, d, l, rw, el);
      do_cmd(s, d, l, rw, el, poke, noise, r);
      checks++;
      if (r.done_at !== e.done_at || r.err !== e.err || r.abort !== e.abort) begin
        errors++; $display("FAIL rand[%0d]_done: got at=%0d err=%0d abort=%0d expected %0d %0d %0d",
                           n, r.done_at, r.err, r.abort, e.done_at, e.err, e.abort);
      end
      checks++;
      if (r.vcyc !== e.vcyc || r.bad_fields !== 0) begin
        errors++; $display("FAIL rand[%0d]_desc: got vcyc=%0d bad=%0d expected %0d 0",
                           n, r.vcyc, r.bad_fields, e.vcyc);
      end
      checks++;
      if (r.ndone !== 1 || r.nabort !== int'(e.abort) || r.busy_bad !== 0 || r.stray_err !== 0) begin
        errors++; $display("FAIL rand[%0d]_pulses: got ndone=%0d nabort=%0d busy_bad=%0d stray=%0d expected 1 %0d 0 0",
                           n, r.ndone, r.nabort, r.busy_bad, r.stray_err, e.abort);
      end
    end
  endtask

  task automatic test_reset_busy();
    res_t r;
    int   late_done;
    int   late_abort;
    bus.src_addr = 32'h3000; bus.dst_addr = 32'h4000; bus.length = 32'h80;
    bus.start = 1'b1; bus.desc_ready = 1'b1; bus.eng_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1 || bus.desc_valid !== 1'b0) begin
      errors++; $display("FAIL rst_busy_pre: got busy=%0d valid=%0d expected 1 0", bus.busy, bus.desc_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.desc_ready = 1'b0;
    checks++;
    if ({bus.done, bus.err_code, bus.busy, bus.desc_valid, bus.eng_abort,
         bus.desc_src, bus.desc_dst, bus.desc_len} !== 102'b0) begin
      errors++; $display("FAIL rst_busy_outputs: got ctrl=%b fields=%h expected 0",
                         {bus.done, bus.err_code, bus.busy, bus.desc_valid, bus.eng_abort},
                         {bus.desc_src, bus.desc_dst, bus.desc_len});
    end
    late_done = 0; late_abort = 0;
    repeat (TO + 4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) late_done++;
      if (bus.eng_abort === 1'b1) late_abort++;
    end
    checks++;
    if (late_done !== 0 || late_abort !== 0) begin
      errors++; $display("FAIL rst_busy_quiet: got done=%0d abort=%0d expected 0 0", late_done, late_abort);
    end
    do_cmd(32'h5000, 32'h6000, 32'h20, 1, 3, 1'b0, 1'b0, r);
    checks++;
    if (r.done_at !== 8 || r.err !== 2'd0 || r.ndone !== 1 || r.bad_fields !== 0) begin
      errors++; $display("FAIL rst_busy_fresh: got at=%0d err=%0d ndone=%0d bad=%0d expected 8 0 1 0",
                         r.done_at, r.err, r.ndone, r.bad_fields);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_reject();
    test_align();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
